// File: rtl/clk_period_monitor_if.sv
// Bundles the monitored clock input and the measurement results.
// master = the monitor itself, slave = whoever drives sig_in and consumes results.
interface clk_period_monitor_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 sig_in;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] high_time;
  logic                 valid;
  logic                 in_tol;
  logic                 stopped;
  logic                 LOCKED;

  modport master (
    input  sig_in,
    output period, high_time, valid, in_tol, stopped, LOCKED
  );

  modport slave (
    output sig_in,
    input  period, high_time, valid, in_tol, stopped, LOCKED
  );
endinterface

// File: rtl/clk_period_monitor.sv
// Measures period and high time of a slow, asynchronous clock (sig_in) in
// clk_in cycles, flags stop/timeout, tolerance and a lock indication.
module clk_period_monitor #(
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 1000,
  parameter int EXP_PERIOD = 4,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  clk_period_monitor_if.master  mon
);

  typedef enum logic [1:0] {IDLE, MEASURE, STOPPED} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_VAL = CNT_WIDTH'(TIMEOUT);
  // Lower bound clamps at zero so a large tolerance cannot underflow.
  localparam logic [31:0] TOL_LO = (EXP_PERIOD > TOLERANCE) ? 32'(EXP_PERIOD - TOLERANCE) : 32'd0;
  localparam logic [31:0] TOL_HI = 32'(EXP_PERIOD + TOLERANCE);
  localparam logic [7:0]  LOCK_THR = 8'(LOCK_COUNT);

  state_t               state, state_nxt;
  logic                 s1, s2, s3;
  logic                 rise, fall;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] high_cap, high_cap_nxt;
  logic [CNT_WIDTH-1:0] period_q, period_nxt;
  logic [CNT_WIDTH-1:0] high_q, high_nxt;
  logic                 valid_q, valid_nxt;
  logic                 in_tol_q, in_tol_nxt;
  logic                 stopped_q, stopped_nxt;
  logic                 locked_q, locked_nxt;
  logic [7:0]           lock_cnt, lock_nxt;
  logic                 tol_now;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign tol_now = (32'(cnt) >= TOL_LO) && (32'(cnt) <= TOL_HI);

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State and measurement registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      high_cap  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      in_tol_q  <= 1'b0;
      stopped_q <= 1'b0;
      locked_q  <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      high_cap  <= high_cap_nxt;
      period_q  <= period_nxt;
      high_q    <= high_nxt;
      valid_q   <= valid_nxt;
      in_tol_q  <= in_tol_nxt;
      stopped_q <= stopped_nxt;
      locked_q  <= locked_nxt;
      lock_cnt  <= lock_nxt;
    end
  end

  // Next-state and datapath: a rise always beats a same-cycle timeout.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_cap_nxt = high_cap;
    period_nxt   = period_q;
    high_nxt     = high_q;
    valid_nxt    = 1'b0;
    in_tol_nxt   = in_tol_q;
    stopped_nxt  = stopped_q;
    locked_nxt   = locked_q;
    lock_nxt     = lock_cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt    = MEASURE;
          cnt_nxt      = CNT_WIDTH'(1);
          high_cap_nxt = '0;
        end else if (cnt == TO_VAL) begin
          state_nxt   = STOPPED;
          stopped_nxt = 1'b1;
          locked_nxt  = 1'b0;
          lock_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt   = cnt;
          high_nxt     = high_cap;  // zero if no fall was seen this period
          valid_nxt    = 1'b1;
          in_tol_nxt   = tol_now;
          cnt_nxt      = CNT_WIDTH'(1);
          high_cap_nxt = '0;
          if (tol_now) lock_nxt = (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
          else         lock_nxt = '0;
          locked_nxt   = (lock_nxt >= LOCK_THR);
        end else if (cnt == TO_VAL) begin
          state_nxt   = STOPPED;
          stopped_nxt = 1'b1;
          locked_nxt  = 1'b0;
          lock_nxt    = '0;
        end else begin
          if (fall) high_cap_nxt = cnt;
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOPPED: begin
        // Counter stays frozen; the restarting rise publishes nothing.
        if (rise) begin
          state_nxt    = MEASURE;
          cnt_nxt      = CNT_WIDTH'(1);
          high_cap_nxt = '0;
          stopped_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mon.period    = period_q;
  assign mon.high_time = high_q;
  assign mon.valid     = valid_q;
  assign mon.in_tol    = in_tol_q;
  assign mon.stopped   = stopped_q;
  assign mon.LOCKED    = locked_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed plus table-driven random checks of clk_period_monitor at defaults.
// sig_in is driven at the falling edge and outputs sampled at the falling edge,
// so a rise driven in tick r is first sampled at that tick's rising edge and
// the resulting valid is visible after tick r+2 (seen by the edge of tick r+3).
module tb_clk_period_monitor;
  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_in = ~clk_in;

  clk_period_monitor_if #(.CNT_WIDTH(16)) mif ();

  clk_period_monitor #(
    .CNT_WIDTH(16), .TIMEOUT(1000), .EXP_PERIOD(4), .TOLERANCE(0), .LOCK_COUNT(4)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .mon    (mif.master)
  );

  int n_tot  = 0;
  int n_pass = 0;
  int tickno = 0;
  int rise_tick = 0;
  // Captured from the most recent valid pulse.
  int vcnt = 0;
  int vtick = 0;
  logic [31:0] vper, vht;
  logic vtol, vlock;

  logic rs [0:2047];
  bit   ev [0:2047];
  int   ep [0:2047];
  int   eh [0:2047];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input logic s);
    mif.sig_in = s;
    @(posedge clk_in);
    @(negedge clk_in);
    if (mif.valid === 1'b1) begin
      vcnt++;
      vper  = 32'(mif.period);
      vht   = 32'(mif.high_time);
      vtol  = mif.in_tol;
      vlock = mif.LOCKED;
      vtick = tickno;
    end
    tickno++;
  endtask

  task automatic wave(input int p, input int h);
    rise_tick = tickno;
    for (int k = 0; k < p; k++) tick(k < h);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"},  32'(mif.period), 0);
    check({tag, "_high"},    32'(mif.high_time), 0);
    check({tag, "_valid"},   32'(mif.valid), 0);
    check({tag, "_in_tol"},  32'(mif.in_tol), 0);
    check({tag, "_stopped"}, 32'(mif.stopped), 0);
    check({tag, "_locked"},  32'(mif.LOCKED), 0);
  endtask

  initial begin
    int base, t, p, h, pp, ph, stop_at;
    mif.sig_in = 1'b0;
    @(negedge clk_in);

    // Reset state
    rst = 1'b1;
    tick(0); tick(0);
    rst = 1'b0;
    check_zero("reset");

    // Period 4, 2 high: first rise only starts; second rise publishes.
    wave(4, 2);
    check("first_rise_no_valid", 32'(vcnt), 0);
    wave(4, 2);
    check("v1_count", 32'(vcnt), 1);
    check("v1_period", vper, 4);
    check("v1_high", vht, 2);
    check("v1_in_tol", 32'(vtol), 1);
    check("v1_latency", 32'(vtick), 32'(rise_tick + 2));
    check("v1_locked", 32'(vlock), 0);
    wave(4, 2); wave(4, 2);
    check("v3_locked", 32'(vlock), 0);
    wave(4, 2);
    check("v4_count", 32'(vcnt), 4);
    check("v4_locked", 32'(vlock), 1);

    // One 6-cycle period drops lock in the same valid cycle.
    wave(6, 3);
    wave(4, 2);
    check("bad_period", vper, 6);
    check("bad_high", vht, 3);
    check("bad_in_tol", 32'(vtol), 0);
    check("bad_locked", 32'(vlock), 0);
    wave(4, 2); wave(4, 2); wave(4, 2);
    check("relock3_locked", 32'(vlock), 0);
    wave(4, 2);
    check("relock4_locked", 32'(vlock), 1);
    check("relock4_period", vper, 4);

    // Hold low: timeout fires exactly 1000 cycles after the last rise is processed.
    stop_at = rise_tick + 1002;
    while (tickno < stop_at) tick(0);
    check("pre_timeout_stopped", 32'(mif.stopped), 0);
    check("pre_timeout_locked", 32'(mif.LOCKED), 1);
    tick(0);
    check("timeout_stopped", 32'(mif.stopped), 1);
    check("timeout_locked", 32'(mif.LOCKED), 0);
    check("timeout_period_held", 32'(mif.period), 4);
    base = vcnt;
    wave(4, 2);
    check("restart_no_valid", 32'(vcnt), 32'(base));
    check("restart_stopped", 32'(mif.stopped), 0);
    wave(4, 2);
    check("restart_valid", 32'(vcnt), 32'(base + 1));
    check("restart_period", vper, 4);

    // Rise lands in the very cycle cnt reaches TIMEOUT: rise wins.
    wave(1000, 500);
    wave(4, 2);
    check("edge_timeout_period", vper, 1000);
    check("edge_timeout_high", vht, 500);
    check("edge_timeout_in_tol", 32'(vtol), 0);
    check("edge_timeout_stopped", 32'(mif.stopped), 0);

    // Reset during a high phase discards everything.
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_zero("midreset");
    tick(0); tick(0); tick(0);
    base = vcnt;
    wave(4, 2);
    check("post_reset_no_valid", 32'(vcnt), 32'(base));
    wave(4, 3);
    check("post_reset_valid", 32'(vcnt), 32'(base + 1));
    check("post_reset_period", vper, 4);
    check("post_reset_high", vht, 2);

    // Random periods 2..50 against a per-tick reference table.
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    for (int i = 0; i < 2048; i++) begin rs[i] = 1'b0; ev[i] = 1'b0; ep[i] = 0; eh[i] = 0; end
    t = 0; pp = 0; ph = 0;
    for (int i = 0; i < 31; i++) begin
      if (i == 30) begin p = 4; h = 2; end
      else begin p = int'($urandom_range(2, 50)); h = int'($urandom_range(1, p - 1)); end
      for (int k = 0; k < p; k++) rs[t + k] = (k < h);
      if (i > 0) begin ev[t + 2] = 1'b1; ep[t + 2] = pp; eh[t + 2] = ph; end
      t += p; pp = p; ph = h;
    end
    for (int i = 0; i < t; i++) begin
      tick(rs[i]);
      check("rand_valid", 32'(mif.valid), 32'(ev[i]));
      if (ev[i]) begin
        check("rand_period", 32'(mif.period), 32'(ep[i]));
        check("rand_high", 32'(mif.high_time), 32'(eh[i]));
        check("rand_in_tol", 32'(mif.in_tol), 32'(ep[i] == 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
